vram_access_arbiter: RTL and testbench
======================================

Name: vram_access_arbiter

Overview:
- Owns the single port of the frame-buffer RAM and shares it between the display scan-out path and a pixel-writer requester.
- Display reads have absolute priority while video is on. Writer requests are buffered in a small FIFO and drained to RAM only during blanking.
- Sits between the VGA sync generator (video_on, pixel_x, pixel_y) and the pixel/RGB output stage.
- Frame buffer is downscaled: each RAM cell covers a 2^SCALE_SHIFT square of screen pixels.

Parameters:
- ADDR_W, 15: RAM address width.
- H_CELLS, 160: RAM cells per row (640 >> SCALE_SHIFT).
- V_CELLS, 120: RAM rows (480 >> SCALE_SHIFT).
- SCALE_SHIFT, 2: log2 of screen pixels per cell edge.
- FIFO_DEPTH, 4: write-FIFO entries (power of 2).
- DATA_W, 12: pixel colour width (4:4:4 RGB).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- video_on  in  1  active-display flag from sync generator
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan row
- wr_req  in  1  writer request valid
- wr_addr  in  ADDR_W  writer cell address
- wr_data  in  DATA_W  writer colour
- wr_ready  out  1  FIFO can accept; a transfer occurs when wr_req && wr_ready at a rising edge
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; synchronous, valid one cycle after address
- RGB  out  DATA_W  colour to DAC pins
- fifo_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- wr_err  out  1  sticky: out-of-range write dropped

Behaviour:
- Clock and reset: one clock domain on clk. reset is synchronous, active-high; it is sampled only at the rising edge of clk.
- Reset values: all registered outputs are 0, including wr_ready, mem_we, RGB, fifo_count and wr_err. The FIFO is emptied and the FSM enters BLANK_IDLE.
  - wr_ready rises on the first edge after reset deasserts.
  - Reset mid-drain discards FIFO contents; no partial write is issued after reset.
- FSM states (all outputs registered):
  - ACTIVE: entered when video_on=1. Each cycle: mem_we=0, mem_addr = (pixel_y>>SCALE_SHIFT)*H_CELLS + (pixel_x>>SCALE_SHIFT).
  - BLANK_IDLE: video_on=0 and FIFO empty. mem_we=0, mem_addr holds.
  - BLANK_WRITE: video_on=0 and FIFO non-empty. Pops one entry per cycle; mem_we=1, mem_addr/mem_wdata come from the FIFO head.
  - video_on=1 forces ACTIVE on the next cycle from any state, pre-empting a drain. Entries not yet popped stay queued.
  - Transition rules are re-evaluated every cycle from video_on and FIFO state.
- Display latency: address issued at cycle N, mem_rdata valid at N+1, RGB registered at N+2. video_on is delayed 2 cycles alongside the data.
  - RGB = mem_rdata when the delayed video_on=1, else 12'h000.
  - Write cycles therefore never reach RGB.
- FIFO:
  - wr_ready = (fifo_count < FIFO_DEPTH) as a registered flag.
  - Simultaneous push and pop keeps the count unchanged.
  - A pop in the same cycle the FIFO is full does not make wr_ready high in that cycle; it rises the following cycle.
  - Push into an empty FIFO during blanking is popped no earlier than the next cycle (1-cycle minimum latency to mem_we).
- Write range check: if wr_addr >= H_CELLS*V_CELLS at push time, the entry is accepted (handshake completes) but discarded. wr_err is set and stays 1 until reset.
- Ordering: writes reach RAM in acceptance order. Writes to the same address resolve last-wins.

Test Plan:
- Reset held 3 cycles, then released -> wr_ready=0, RGB=0, mem_we=0 during reset; wr_ready=1 one cycle after release.
- video_on=1, pixel_x=17, pixel_y=9 (SCALE_SHIFT=2) -> mem_addr=2*160+4=324 next cycle; mem_rdata=12'hF0A returned -> RGB=12'hF0A two cycles after address.
- 4 pushes during ACTIVE -> wr_ready=0 after the 4th, mem_we never 1. After video_on falls -> 4 consecutive mem_we=1 cycles in push order, then BLANK_IDLE, fifo_count=0.
- Drain of 3 entries with video_on rising after the 1st write -> exactly 1 write issued, ACTIVE next cycle, fifo_count=2. Remaining 2 writes are issued in the next blanking.
- Push wr_addr=19200 -> handshake completes, no mem_we for it, wr_err=1 held until reset.
- FIFO full during blanking with wr_req held -> one pop and push per cycle after wr_ready recovers; fifo_count never exceeds 4.

Source files
------------

// File: rtl/vram_access_arbiter_if.sv
// Writer handshake and frame-buffer RAM port shared between the arbiter and its environment.
interface vram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 12
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_access_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out owns the RAM while video is on,
// buffered pixel writes drain only during blanking.
module vram_access_arbiter #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned H_CELLS     = 160,
  parameter int unsigned V_CELLS     = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DATA_W      = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        video_on,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  vram_access_arbiter_if.slave        bus,
  output logic [DATA_W-1:0]           RGB,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        wr_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CELLS = H_CELLS * V_CELLS;

  typedef enum logic [1:0] {
    BLANK_IDLE  = 2'd0,
    ACTIVE      = 2'd1,
    BLANK_WRITE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_ready_q, wr_ready_d;
  logic              wr_err_q, wr_err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              vid1_q, vid2_q;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic              push, store, pop, in_range;
  logic [ADDR_W-1:0] scan_addr;

  // Next-state, FIFO bookkeeping and registered-output values
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    push        = bus.wr_req && wr_ready_q;
    in_range    = bus.wr_addr < ADDR_W'(CELLS);
    store       = push && in_range;
    scan_addr   = ADDR_W'(pixel_y >> SCALE_SHIFT) * ADDR_W'(H_CELLS)
                + ADDR_W'(pixel_x >> SCALE_SHIFT);

    if (video_on)              state_d = ACTIVE;
    else if (count_q != '0)    state_d = BLANK_WRITE;
    else                       state_d = BLANK_IDLE;

    pop = (state_d == BLANK_WRITE);

    case (state_d)
      ACTIVE:      mem_addr_d = scan_addr;
      BLANK_WRITE: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = fifo_addr_q[rptr_q];
        mem_wdata_d = fifo_data_q[rptr_q];
      end
      default:     mem_addr_d = mem_addr_q;
    endcase

    count_d    = count_q + CNT_W'(store) - CNT_W'(pop);
    wptr_d     = store ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d     = pop   ? rptr_q + PTR_W'(1) : rptr_q;
    wr_ready_d = count_d < CNT_W'(FIFO_DEPTH);
    wr_err_d   = wr_err_q | (push && !in_range);
    rgb_d      = vid2_q ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BLANK_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wr_ready_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rgb_q       <= '0;
      vid1_q      <= 1'b0;
      vid2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wr_ready_q  <= wr_ready_d;
      wr_err_q    <= wr_err_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rgb_q       <= rgb_d;
      vid1_q      <= video_on;
      vid2_q      <= vid1_q;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count/pointers
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_addr_q[wptr_q] <= bus.wr_addr;
      fifo_data_q[wptr_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign RGB           = rgb_q;
  assign fifo_count    = count_q;
  assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a synchronous RAM model and write logger.
module tb_vram_access_arbiter;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] pixel_x, pixel_y;
  logic [DATA_W-1:0] RGB;
  logic [2:0] fifo_count;
  logic       wr_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0]        ram [32768];
  logic [ADDR_W+DATA_W-1:0] wlog [$];
  logic [ADDR_W+DATA_W-1:0] exp_q [$];
  logic                     overflow_seen = 1'b0;

  vram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_access_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .bus        (bus),
    .RGB        (RGB),
    .fifo_count (fifo_count),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data valid one cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (!reset && bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_wdata});
    if (fifo_count > 3'd4) overflow_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = '0;
    ram[324] = 12'hF0A;
    reset = 1'b1; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    // Reset held three cycles
    step(1);
    check_eq("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check_eq("rst_rgb", 32'(RGB), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    step(2);
    check_eq("rst_wr_ready_hold", 32'(bus.wr_ready), 32'd0);
    reset = 1'b0;
    step(1);
    check_eq("wr_ready_after_rst", 32'(bus.wr_ready), 32'd1);
    check_eq("wr_err_after_rst", 32'(wr_err), 32'd0);

    // Display read path: (9>>2)*160 + (17>>2) = 324
    video_on = 1'b1; pixel_x = 10'd17; pixel_y = 10'd9;
    step(1);
    check_eq("scan_addr", 32'(bus.mem_addr), 32'd324);
    check_eq("scan_we", 32'(bus.mem_we), 32'd0);
    step(1);
    check_eq("rgb_not_yet", 32'(RGB), 32'd0);
    step(1);
    check_eq("rgb_pixel", 32'(RGB), 32'hF0A);

    // Four pushes during active video fill the FIFO without any RAM write
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      bus.wr_req = 1'b1; bus.wr_addr = 15'(100 + k); bus.wr_data = 12'(12'h111 * (k + 1));
      step(1);
    end
    bus.wr_req = 1'b0;
    check_eq("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    check_eq("full_count", 32'(fifo_count), 32'd4);
    step(2);
    check_eq("active_no_writes", 32'(wlog.size()), 32'd0);
    check_eq("active_rgb", 32'(RGB), 32'hF0A);
    video_on = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check_eq("drain_we", 32'(bus.mem_we), 32'd1);
      check_eq("drain_addr", 32'(bus.mem_addr), 32'(100 + k));
      check_eq("drain_data", 32'(bus.mem_wdata), 32'(12'h111 * (k + 1)));
    end
    step(1);
    check_eq("drain_done_we", 32'(bus.mem_we), 32'd0);
    check_eq("drain_done_count", 32'(fifo_count), 32'd0);
    check_eq("blank_rgb", 32'(RGB), 32'd0);

    // Drain pre-empted by video after the first write
    video_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.wr_req = 1'b1; bus.wr_addr = 15'(200 + k); bus.wr_data = 12'(12'hA00 + k);
      step(1);
    end
    bus.wr_req = 1'b0;
    video_on = 1'b0;
    step(1);
    check_eq("pre_we1", 32'(bus.mem_we), 32'd1);
    check_eq("pre_addr1", 32'(bus.mem_addr), 32'd200);
    video_on = 1'b1;
    step(1);
    check_eq("pre_we_stop", 32'(bus.mem_we), 32'd0);
    check_eq("pre_count", 32'(fifo_count), 32'd2);
    check_eq("pre_scan_addr", 32'(bus.mem_addr), 32'd324);
    step(3);
    check_eq("pre_count_hold", 32'(fifo_count), 32'd2);
    video_on = 1'b0;
    step(1);
    check_eq("resume_we1", 32'(bus.mem_we), 32'd1);
    check_eq("resume_addr1", 32'(bus.mem_addr), 32'd201);
    step(1);
    check_eq("resume_addr2", 32'(bus.mem_addr), 32'd202);
    check_eq("resume_data2", 32'(bus.mem_wdata), 32'hA02);
    step(1);
    check_eq("resume_done", 32'(bus.mem_we), 32'd0);

    // Range check: last legal cell is written, 19200 is accepted and dropped
    bus.wr_req = 1'b1; bus.wr_addr = 15'd19200; bus.wr_data = 12'hBAD;
    check_eq("oor_ready", 32'(bus.wr_ready), 32'd1);
    step(1);
    bus.wr_req = 1'b0;
    check_eq("oor_err", 32'(wr_err), 32'd1);
    check_eq("oor_count", 32'(fifo_count), 32'd0);
    step(1);
    check_eq("oor_no_we", 32'(bus.mem_we), 32'd0);
    bus.wr_req = 1'b1; bus.wr_addr = 15'd19199; bus.wr_data = 12'hABC;
    step(1);
    bus.wr_req = 1'b0;
    check_eq("edge_count", 32'(fifo_count), 32'd1);
    check_eq("edge_latency_we", 32'(bus.mem_we), 32'd0);
    step(1);
    check_eq("edge_we", 32'(bus.mem_we), 32'd1);
    check_eq("edge_addr", 32'(bus.mem_addr), 32'd19199);
    step(3);
    check_eq("err_sticky", 32'(wr_err), 32'd1);

    // Full FIFO with wr_req held through blanking: one push and one pop per cycle
    wlog.delete();
    exp_q.delete();
    video_on = 1'b1;
    bus.wr_req = 1'b1;
    for (int k = 0, c = 0; c < 6; c++) begin
      bus.wr_addr = 15'(1000 + k); bus.wr_data = 12'(k * 7 + 1);
      if (bus.wr_ready) begin
        exp_q.push_back({bus.wr_addr, bus.wr_data});
        k++;
      end
      step(1);
    end
    check_eq("hold_full_count", 32'(fifo_count), 32'd4);
    check_eq("hold_full_ready", 32'(bus.wr_ready), 32'd0);
    video_on = 1'b0;
    bus.wr_addr = 15'd1004; bus.wr_data = 12'(4 * 7 + 1);
    step(1);
    check_eq("recover_ready", 32'(bus.wr_ready), 32'd1);
    check_eq("recover_count", 32'(fifo_count), 32'd3);
    for (int k = 4; k < 10; k++) begin
      bus.wr_addr = 15'(1000 + k); bus.wr_data = 12'(k * 7 + 1);
      exp_q.push_back({bus.wr_addr, bus.wr_data});
      step(1);
      check_eq("stream_count", 32'(fifo_count), 32'd3);
      check_eq("stream_we", 32'(bus.mem_we), 32'd1);
    end
    bus.wr_req = 1'b0;
    step(4);
    check_eq("stream_empty", 32'(fifo_count), 32'd0);
    check_eq("stream_nwrites", 32'(wlog.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < wlog.size()) check_eq("stream_order", 32'(wlog[k]), 32'(exp_q[k]));
    end
    check_eq("no_overflow", 32'(overflow_seen), 32'd0);

    // Reset in the middle of a drain discards the FIFO
    video_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.wr_req = 1'b1; bus.wr_addr = 15'(300 + k); bus.wr_data = 12'(12'h500 + k);
      step(1);
    end
    bus.wr_req = 1'b0;
    video_on = 1'b0;
    step(1);
    check_eq("mid_we", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    step(1);
    check_eq("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.wr_ready), 32'd0);
    check_eq("mid_rst_err", 32'(wr_err), 32'd0);
    reset = 1'b0;
    wlog.delete();
    step(4);
    check_eq("post_rst_writes", 32'(wlog.size()), 32'd0);
    check_eq("post_rst_ready", 32'(bus.wr_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
